// File: rtl/voice_alloc_pkg.sv
// Shared constants and types for the polyphonic voice allocator.
//   OSC_VOICES / MIDI_PAYLOAD_BITS : default voice count and note width
//   STEAL_OLDEST / STEAL_NONE      : STEAL_MODE parameter encodings
//   ev_e                           : the single event handled in a cycle
package voice_alloc_pkg;

  localparam int unsigned OSC_VOICES        = 4;
  localparam int unsigned MIDI_PAYLOAD_BITS = 7;

  localparam int unsigned STEAL_OLDEST = 1;
  localparam int unsigned STEAL_NONE   = 0;

  // Winning event after priority resolution (panic > off > on).
  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_PANIC = 2'd1,
    EV_OFF   = 2'd2,
    EV_ON    = 2'd3
  } ev_e;

endpackage

// File: rtl/voice_alloc_if.sv
// Note-event / voice-bank bus between the MIDI decoder and the oscillators.
//   note_i, noteOnStrb_i, noteOffStrb_i, panic_i : note events (master -> slave)
//   voiceNote_o, voiceGate_o, voiceLoadStrb_o,
//   activeCount_o, droppedStrb_o                 : voice state (slave -> master)
interface voice_alloc_if
  import voice_alloc_pkg::*;
#(
  parameter int unsigned VOICES = OSC_VOICES,
  parameter int unsigned NOTE_W = MIDI_PAYLOAD_BITS
);
  localparam int unsigned CNT_W = $clog2(VOICES + 1);

  logic [NOTE_W-1:0]        note_i;
  logic                     noteOnStrb_i;
  logic                     noteOffStrb_i;
  logic                     panic_i;
  logic [VOICES*NOTE_W-1:0] voiceNote_o;
  logic [VOICES-1:0]        voiceGate_o;
  logic [VOICES-1:0]        voiceLoadStrb_o;
  logic [CNT_W-1:0]         activeCount_o;
  logic                     droppedStrb_o;

  modport master (
    output note_i, noteOnStrb_i, noteOffStrb_i, panic_i,
    input  voiceNote_o, voiceGate_o, voiceLoadStrb_o, activeCount_o, droppedStrb_o
  );

  modport slave (
    input  note_i, noteOnStrb_i, noteOffStrb_i, panic_i,
    output voiceNote_o, voiceGate_o, voiceLoadStrb_o, activeCount_o, droppedStrb_o
  );
endinterface

// File: rtl/voice_alloc_lru.sv
// Least-recently-allocated rank tracker. rank 0 = newest, VOICES-1 = oldest.
//   clk_i, nrst_i   : clock, async active-low reset (rank[i] = i)
//   i_touch_vld     : move voice i_touch_idx to rank 0 this cycle
//   i_touch_idx     : voice being allocated
//   o_oldest_idx_c  : voice currently holding rank VOICES-1
//   o_rank_c        : rank of voice i at [i*IDX_W +: IDX_W]
module voice_alloc_lru #(
  parameter int unsigned VOICES = 4,
  localparam int unsigned IDX_W = $clog2(VOICES)
) (
  input  logic                     clk_i,
  input  logic                     nrst_i,
  input  logic                     i_touch_vld,
  input  logic [IDX_W-1:0]         i_touch_idx,
  output logic [IDX_W-1:0]         o_oldest_idx_c,
  output logic [VOICES*IDX_W-1:0]  o_rank_c
);

  logic [IDX_W-1:0] r_rank     [VOICES];
  logic [IDX_W-1:0] w_rank_nxt [VOICES];
  logic [IDX_W-1:0] w_touch_rank;

  // Voices newer than the touched one age by one; the touched one becomes newest.
  always_comb begin
    w_touch_rank = r_rank[i_touch_idx];
    for (int i = 0; i < VOICES; i++) begin
      w_rank_nxt[i] = r_rank[i];
      if (i_touch_vld) begin
        if (IDX_W'(i) == i_touch_idx) begin
          w_rank_nxt[i] = '0;
        end else if (r_rank[i] < w_touch_rank) begin
          w_rank_nxt[i] = r_rank[i] + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int i = 0; i < VOICES; i++) begin
        r_rank[i] <= IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        r_rank[i] <= w_rank_nxt[i];
      end
    end
  end

  // Oldest lookup and flattened rank view.
  always_comb begin
    o_oldest_idx_c = '0;
    o_rank_c       = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (r_rank[i] == IDX_W'(VOICES - 1)) begin
        o_oldest_idx_c = IDX_W'(i);
      end
      o_rank_c[i*IDX_W +: IDX_W] = r_rank[i];
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note events onto VOICES oscillator voices.
//   clk_i, nrst_i : clock, async active-low reset
//   bus (slave)   : note events in; per-voice note/gate/load strobe, active
//                   count and drop strobe out (all registered)
module voice_alloc
  import voice_alloc_pkg::*;
#(
  parameter int unsigned VOICES     = OSC_VOICES,
  parameter int unsigned NOTE_W     = MIDI_PAYLOAD_BITS,
  parameter int unsigned STEAL_MODE = STEAL_OLDEST
) (
  input  logic         clk_i,
  input  logic         nrst_i,
  voice_alloc_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(VOICES);
  localparam int unsigned CNT_W = $clog2(VOICES + 1);

  logic [VOICES-1:0][NOTE_W-1:0] r_note, w_note_nxt;
  logic [VOICES-1:0]             r_gate, w_gate_nxt;
  logic [VOICES-1:0]             r_load, w_load_nxt;
  logic [CNT_W-1:0]              r_count, w_count_nxt;
  logic                          r_drop, w_drop_nxt;

  ev_e                    w_ev;
  logic                   w_match_hit, w_free_hit;
  logic [IDX_W-1:0]       w_match_idx, w_free_idx, w_oldest_idx;
  logic                   w_touch;
  logic [IDX_W-1:0]       w_touch_idx;
  logic [VOICES*IDX_W-1:0] w_rank;
  logic [VOICES-1:0]      w_rank_seen;
  logic                   w_rank_ok;

  voice_alloc_lru #(.VOICES(VOICES)) u_lru (
    .clk_i          (clk_i),
    .nrst_i         (nrst_i),
    .i_touch_vld    (w_touch),
    .i_touch_idx    (w_touch_idx),
    .o_oldest_idx_c (w_oldest_idx),
    .o_rank_c       (w_rank)
  );

  // Only the highest-priority strobe survives.
  always_comb begin
    w_ev = EV_NONE;
    if (bus.panic_i)            w_ev = EV_PANIC;
    else if (bus.noteOffStrb_i) w_ev = EV_OFF;
    else if (bus.noteOnStrb_i)  w_ev = EV_ON;
  end

  // Lowest-index gated match and lowest-index free voice (descending loop, last hit wins).
  always_comb begin
    w_match_hit = 1'b0;
    w_match_idx = '0;
    w_free_hit  = 1'b0;
    w_free_idx  = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (r_gate[i] && (r_note[i] == bus.note_i)) begin
        w_match_hit = 1'b1;
        w_match_idx = IDX_W'(i);
      end
      if (!r_gate[i]) begin
        w_free_hit = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  // Next voice state for the winning event.
  always_comb begin
    w_note_nxt  = r_note;
    w_gate_nxt  = r_gate;
    w_load_nxt  = '0;
    w_drop_nxt  = 1'b0;
    w_touch     = 1'b0;
    w_touch_idx = '0;
    unique case (w_ev)
      EV_PANIC: w_gate_nxt = '0;
      EV_OFF: begin
        if (w_match_hit) w_gate_nxt[w_match_idx] = 1'b0;
      end
      EV_ON: begin
        if (w_match_hit) begin
          w_touch     = 1'b1;
          w_touch_idx = w_match_idx;
        end else if (w_free_hit) begin
          w_touch     = 1'b1;
          w_touch_idx = w_free_idx;
        end else if (STEAL_MODE == STEAL_OLDEST) begin
          w_touch     = 1'b1;
          w_touch_idx = w_oldest_idx;
        end else begin
          w_drop_nxt  = 1'b1;
        end
        if (w_touch) begin
          w_note_nxt[w_touch_idx] = bus.note_i;
          w_gate_nxt[w_touch_idx] = 1'b1;
          w_load_nxt[w_touch_idx] = 1'b1;
        end
      end
      default: ;
    endcase
    w_count_nxt = '0;
    for (int i = 0; i < VOICES; i++) begin
      w_count_nxt = w_count_nxt + CNT_W'(w_gate_nxt[i]);
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_note  <= '0;
      r_gate  <= '0;
      r_load  <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_note  <= w_note_nxt;
      r_gate  <= w_gate_nxt;
      r_load  <= w_load_nxt;
      r_count <= w_count_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  assign bus.voiceNote_o     = r_note;
  assign bus.voiceGate_o     = r_gate;
  assign bus.voiceLoadStrb_o = r_load;
  assign bus.activeCount_o   = r_count;
  assign bus.droppedStrb_o   = r_drop;

  // Ranks must stay a permutation: every rank value owned by some voice.
  always_comb begin
    w_rank_seen = '0;
    for (int i = 0; i < VOICES; i++) begin
      w_rank_seen[w_rank[i*IDX_W +: IDX_W]] = 1'b1;
    end
    w_rank_ok = &w_rank_seen;
  end

  a_rank_perm: assert property (@(posedge clk_i) disable iff (!nrst_i) w_rank_ok);
  a_count_max: assert property (@(posedge clk_i) disable iff (!nrst_i) r_count <= CNT_W'(VOICES));

endmodule
